// File: rtl/viterbi_traceback.sv
// viterbi_traceback: traceback unit of the Viterbi decoder.
// Walks TB_DEPTH survivor pages backwards from the best-metric state, reading
// one survivor byte per page from the MMU and reconstructing predecessors.
// The final DEC_LEN steps produce decoded bits.
// Optional feature: define TB_REVERSE_EN to buffer decoded bits in a LIFO and
// emit them oldest-first during a FLUSH phase after the last step.
module viterbi_traceback #(
   parameter int WD_STATE = 6,
   parameter int RD_LAT   = 2,
   parameter int TB_DEPTH = 32,
   parameter int DEC_LEN  = 8
) (
   input  logic                CLOCK,
   input  logic                Reset,
   input  logic                Start,
   input  logic [WD_STATE-1:0] StartState,
   output logic                Init,
   output logic                TBStep,
   output logic [WD_STATE-4:0] AddressTB,
   input  logic [7:0]          DataTB,
   output logic                Busy,
   output logic                DecValid,
   output logic                DecBit,
   output logic                Done
);

   localparam int CW        = $clog2(TB_DEPTH + 1);
   localparam int WW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam int WAIT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;
   localparam int EMIT_FROM = TB_DEPTH - DEC_LEN;

`ifdef TB_REVERSE_EN
   localparam int PW = (DEC_LEN > 1) ? $clog2(DEC_LEN) : 1;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, UPDATE, FLUSH} fsm_t;
`else
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, UPDATE} fsm_t;
`endif

   fsm_t                fsm;
   fsm_t                fsm_next;
   logic [WD_STATE-1:0] trel;
   logic [CW-1:0]       step_cnt;
   logic [WW-1:0]       wait_cnt;
   logic                surv_bit;
   logic                dec;
   logic                last_step;
   logic                emit;

`ifdef TB_REVERSE_EN
   logic [DEC_LEN-1:0]  lifo;
   logic [DEC_LEN-1:0]  lifo_push;
   logic [PW-1:0]       pop_cnt;
   logic                last_pop;
`else
   logic                done_r;
`endif

   assign surv_bit  = DataTB[trel[2:0]];
   assign dec       = trel[WD_STATE-1];
   assign last_step = (step_cnt == CW'(TB_DEPTH - 1));

   // The trellis state only changes at the end of UPDATE, so the address taken
   // straight from it is already valid in the ISSUE cycle and stays stable.
   assign AddressTB = trel[WD_STATE-1:3];

   if (EMIT_FROM > 0) begin : g_emit_late
      assign emit = (step_cnt >= CW'(EMIT_FROM));
   end else begin : g_emit_all
      assign emit = 1'b1;
   end

`ifdef TB_REVERSE_EN
   assign last_pop = (pop_cnt == PW'(DEC_LEN - 1));

   // Newest decoded bit enters at bit 0, so bit 0 is always the next to pop.
   always_comb begin
      lifo_push    = lifo << 1;
      lifo_push[0] = dec;
   end
`endif

   // FSM state register.
   always_ff @(posedge CLOCK) begin
      if (Reset) fsm <= IDLE;
      else       fsm <= fsm_next;
   end

   // Next-state and strobe outputs.
   always_comb begin
      fsm_next = fsm;
      Init     = 1'b0;
      TBStep   = 1'b0;
      DecValid = 1'b0;
      DecBit   = 1'b0;
      Busy     = (fsm != IDLE);
`ifdef TB_REVERSE_EN
      Done     = 1'b0;
`else
      Done     = done_r;
`endif
      case (fsm)
         IDLE: begin
            if (Start) fsm_next = ISSUE;
         end
         ISSUE: begin
            Init     = (step_cnt == '0);
            fsm_next = (RD_LAT > 1) ? WAIT : UPDATE;
         end
         WAIT: begin
            if (wait_cnt == WW'(WAIT_LAST)) fsm_next = UPDATE;
         end
         UPDATE: begin
            TBStep = 1'b1;
`ifdef TB_REVERSE_EN
            fsm_next = last_step ? FLUSH : ISSUE;
`else
            DecValid = emit;
            DecBit   = emit & dec;
            fsm_next = last_step ? IDLE : ISSUE;
`endif
         end
`ifdef TB_REVERSE_EN
         FLUSH: begin
            DecValid = 1'b1;
            DecBit   = lifo[0];
            if (last_pop) begin
               Done     = 1'b1;
               Busy     = 1'b0;
               fsm_next = IDLE;
            end
         end
`endif
         default: fsm_next = IDLE;
      endcase
   end

   // Trellis state, step/wait counters and decoded-bit storage.
   always_ff @(posedge CLOCK) begin
      if (Reset) begin
         trel     <= '0;
         step_cnt <= '0;
         wait_cnt <= '0;
`ifdef TB_REVERSE_EN
         lifo     <= '0;
         pop_cnt  <= '0;
`else
         done_r   <= 1'b0;
`endif
      end else begin
`ifndef TB_REVERSE_EN
         done_r <= (fsm == UPDATE) && last_step;
`endif
         case (fsm)
            IDLE: begin
               if (Start) begin
                  trel     <= StartState;
                  step_cnt <= '0;
               end
            end
            ISSUE: wait_cnt <= '0;
            WAIT:  wait_cnt <= wait_cnt + WW'(1);
            UPDATE: begin
               trel     <= {trel[WD_STATE-2:0], surv_bit};
               step_cnt <= step_cnt + CW'(1);
`ifdef TB_REVERSE_EN
               if (emit) lifo <= lifo_push;
               pop_cnt <= '0;
`endif
            end
`ifdef TB_REVERSE_EN
            FLUSH: begin
               lifo    <= lifo >> 1;
               pop_cnt <= pop_cnt + PW'(1);
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback: directed vector table, randomized
// survivor memories against a path-walking reference model, short-depth
// instance, busy re-start, back-to-back starts and mid-run reset.
`timescale 1ns/1ps
module tb_viterbi_traceback;

   localparam int TB     = 32;
   localparam int DL     = 8;
   localparam int RD     = 2;
   localparam int STEP_P = RD + 1;
`ifdef TB_REVERSE_EN
   localparam int DONE_OFF   = TB * STEP_P + DL;
   localparam int S_DONE_OFF = 8 * 2 + 8;
   localparam logic [7:0] S_EXP = 8'h80;
`else
   localparam int DONE_OFF   = TB * STEP_P + 1;
   localparam int S_DONE_OFF = 8 * 2 + 1;
   localparam logic [7:0] S_EXP = 8'h01;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, start_s;
   logic [5:0] ss, ss_s;
   logic       init, tbstep, busy, dvalid, dbit, done;
   logic [2:0] addr;
   logic [7:0] data;
   logic       init_s, tbstep_s, busy_s, dvalid_s, dbit_s, done_s;
   logic [2:0] addr_s;
   logic [7:0] data_s;

   viterbi_traceback #(.WD_STATE(6), .RD_LAT(RD), .TB_DEPTH(TB), .DEC_LEN(DL)) u_main (
      .CLOCK(clk), .Reset(rst), .Start(start), .StartState(ss),
      .Init(init), .TBStep(tbstep), .AddressTB(addr), .DataTB(data),
      .Busy(busy), .DecValid(dvalid), .DecBit(dbit), .Done(done));

   viterbi_traceback #(.WD_STATE(6), .RD_LAT(1), .TB_DEPTH(8), .DEC_LEN(8)) u_short (
      .CLOCK(clk), .Reset(rst), .Start(start_s), .StartState(ss_s),
      .Init(init_s), .TBStep(tbstep_s), .AddressTB(addr_s), .DataTB(data_s),
      .Busy(busy_s), .DecValid(dvalid_s), .DecBit(dbit_s), .Done(done_s));

   // Survivor memory model: one 64-bit survivor word per page, RD-cycle read.
   logic [63:0] surv [64];
   logic [5:0]  page_base, page_q;
   logic [7:0]  rd0, rd1;

   always @(posedge clk) begin
      logic [5:0] pg;
      logic [5:0] idx;
      pg  = init ? page_base : page_q;
      idx = {addr, 3'b000};
      rd0 <= surv[pg][idx +: 8];
      rd1 <= rd0;
      if (init)        page_q <= page_base;
      else if (tbstep) page_q <= page_q - 6'd1;
   end
   assign data = rd1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   // Reference: walk the survivor path from the start state.
   logic [TB-1:0] exp_dec;
   logic [2:0]    exp_addr [TB];

   task automatic compute_model(input logic [5:0] s0, input logic [5:0] p0);
      int unsigned st, pg;
      st = s0;
      for (int k = 0; k < TB; k++) begin
         pg = (int'(p0) + 64 - k) % 64;
         exp_addr[k] = 3'(st / 8);
         exp_dec[k]  = (st >= 32);
         st = (st * 2 + (surv[pg][st] ? 1 : 0)) % 64;
      end
   endtask

   function automatic int dec_cycle(input int i);
`ifdef TB_REVERSE_EN
      return TB * STEP_P + 1 + i;
`else
      return (TB - DL + i + 1) * STEP_P;
`endif
   endfunction

   task automatic run_main(input string nm, input logic [5:0] s0, input logic [5:0] p0,
                           input bit use_tab, input logic [7:0] tab_bits, input bit repulse);
      logic [DL-1:0] expv, gotv;
      int n_init, init_at, n_step, step_bad, addr_bad, n_dec, dec_bad, n_done, done_at, busy_bad, extra;
      n_init = 0; init_at = -1; n_step = 0; step_bad = 0; addr_bad = 0; n_dec = 0;
      dec_bad = 0; n_done = 0; done_at = -1; busy_bad = 0;
      expv = '0; gotv = '0;
      extra = repulse ? 10 : 0;
      compute_model(s0, p0);
      for (int i = 0; i < DL; i++) begin
`ifdef TB_REVERSE_EN
         expv[i] = use_tab ? tab_bits[DL-1-i] : exp_dec[TB-1-i];
`else
         expv[i] = use_tab ? tab_bits[i] : exp_dec[TB-DL+i];
`endif
      end
      @(negedge clk);
      page_base = p0; ss = s0; start = 1'b1;
      for (int n = 1; n <= DONE_OFF + 40; n++) begin
         @(negedge clk);
         if (n == 1) begin start = 1'b0; ss = 6'($urandom); end
         if (repulse && n == 10) begin start = 1'b1; ss = ~s0; end
         if (repulse && n == 11) start = 1'b0;
         if (init) begin if (n_init == 0) init_at = n; n_init++; end
         if (tbstep) begin
            if (n_step < TB) begin
               if (addr != exp_addr[n_step]) addr_bad++;
               if (n != (n_step + 1) * STEP_P) step_bad++;
            end
            n_step++;
         end
         if (dvalid) begin
            if (n_dec < DL) begin
               gotv[n_dec] = dbit;
               if (n != dec_cycle(n_dec)) dec_bad++;
            end
            n_dec++;
         end
         if (busy != (n < DONE_OFF)) busy_bad++;
         if (done) begin if (n_done == 0) done_at = n; n_done++; end
         if (n_done != 0 && n >= done_at + extra) break;
      end
      chk({nm, " done count"}, n_done, 1);
      chk({nm, " done cycle"}, done_at, DONE_OFF);
      chk({nm, " init count"}, n_init, 1);
      chk({nm, " init cycle"}, init_at, 1);
      chk({nm, " tbstep count"}, n_step, TB);
      chk({nm, " tbstep timing errors"}, step_bad, 0);
      chk({nm, " address trace errors"}, addr_bad, 0);
      chk({nm, " decvalid count"}, n_dec, DL);
      chk({nm, " decoded bits"}, gotv, expv);
      chk({nm, " decvalid timing errors"}, dec_bad, 0);
      chk({nm, " busy errors"}, busy_bad, 0);
   endtask

   task automatic run_short();
      logic [7:0] gotv;
      int n_init, n_step, step_bad, n_dec, dec_bad, n_done, done_at;
      n_init = 0; n_step = 0; step_bad = 0; n_dec = 0; dec_bad = 0; n_done = 0; done_at = -1;
      gotv = '0;
      @(negedge clk);
      ss_s = 6'h20; start_s = 1'b1;
      for (int n = 1; n <= S_DONE_OFF + 20; n++) begin
         @(negedge clk);
         if (n == 1) start_s = 1'b0;
         if (init_s) n_init++;
         if (tbstep_s) begin
            if (n != (n_step + 1) * 2) step_bad++;
            n_step++;
         end
         if (dvalid_s) begin
            if (n_dec < 8) begin
               gotv[n_dec] = dbit_s;
`ifdef TB_REVERSE_EN
               if (n != 17 + n_dec) dec_bad++;
`else
               if (n != (n_dec + 1) * 2) dec_bad++;
`endif
            end
            n_dec++;
         end
         if (done_s) begin if (n_done == 0) done_at = n; n_done++; end
         if (n_done != 0) break;
      end
      chk("short done count", n_done, 1);
      chk("short done cycle", done_at, S_DONE_OFF);
      chk("short init count", n_init, 1);
      chk("short tbstep count", n_step, 8);
      chk("short tbstep timing errors", step_bad, 0);
      chk("short decvalid count", n_dec, 8);
      chk("short decoded bits", gotv, S_EXP);
      chk("short decvalid timing errors", dec_bad, 0);
   endtask

   task automatic fill_random();
      for (int p = 0; p < 64; p++) surv[p] = {$urandom, $urandom};
   endtask

   task automatic run_abort();
      int n_step, noise;
      n_step = 0; noise = 0;
      fill_random();
      @(negedge clk);
      page_base = 6'd45; ss = 6'($urandom); start = 1'b1;
      for (int n = 1; n <= DONE_OFF + 40; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (tbstep) n_step++;
         if (n_step == 20) break;
      end
      chk("abort reached step 20", n_step, 20);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy after reset", busy, 0);
      chk("abort tbstep after reset", tbstep, 0);
      for (int n = 0; n < DONE_OFF + 20; n++) begin
         @(negedge clk);
         if (dvalid || done || tbstep || init) noise++;
      end
      chk("abort activity after reset", noise, 0);
   endtask

   typedef struct packed {
      logic [5:0] ss;
      logic [7:0] fill;
      logic [7:0] exp;
   } vec_t;

   initial begin
      vec_t tab [5];
      int bad;
      tab[0] = '{ss: 6'h00, fill: 8'h00, exp: 8'h00};
      tab[1] = '{ss: 6'h00, fill: 8'hFF, exp: 8'hFF};
      tab[2] = '{ss: 6'h3F, fill: 8'hFF, exp: 8'hFF};
      tab[3] = '{ss: 6'h3F, fill: 8'h00, exp: 8'h00};
      tab[4] = '{ss: 6'h00, fill: 8'h0F, exp: 8'hC7};

      rst = 1'b1; start = 1'b1; ss = 6'h2A; start_s = 1'b1; ss_s = 6'h20;
      data_s = 8'h00; page_base = 6'd0; page_q = 6'd0;
      for (int p = 0; p < 64; p++) surv[p] = '0;

      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (busy || init || dvalid || busy_s || init_s || dvalid_s) bad++;
      end
      chk("reset hold activity", bad, 0);
      rst = 1'b0; start = 1'b0; start_s = 1'b0;
      @(negedge clk);
      chk("post-reset main outputs", {init, tbstep, addr, busy, dvalid, dbit, done}, 0);
      chk("post-reset short outputs", {init_s, tbstep_s, addr_s, busy_s, dvalid_s, dbit_s, done_s}, 0);

      // Consecutive table runs also exercise a Start in the cycle after Done.
      for (int i = 0; i < 5; i++) begin
         for (int p = 0; p < 64; p++) surv[p] = {8{tab[i].fill}};
         run_main($sformatf("vec%0d", i), tab[i].ss, 6'd40, 1'b1, tab[i].exp, 1'b0);
      end

      fill_random();
      run_main("repulse", 6'($urandom), 6'd50, 1'b0, 8'h00, 1'b1);

      run_short();

      run_abort();
      fill_random();
      run_main("post-abort", 6'($urandom), 6'd33, 1'b0, 8'h00, 1'b0);

      for (int r = 0; r < 6; r++) begin
         fill_random();
         run_main($sformatf("rand%0d", r), 6'($urandom), 6'(31 + $urandom_range(0, 32)),
                  1'b0, 8'h00, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
